// File: rtl/mmu_fetch_pkg.sv
// Shared types for the MMU word fetcher:
// FSM state encoding and request size codes.
package mmu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } fetch_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Code 3 is folded into a full word.
  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_byte_assembler.sv
// Places one received byte into its little-endian
// lane and sign/zero extends the partial result.
module fetch_byte_assembler
  import mmu_fetch_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [7:0]  i_byte,
  input  logic [1:0]  i_idx,
  input  logic [2:0]  i_nbytes,
  input  logic        i_signed,
  output logic [31:0] o_raw,
  output logic [31:0] o_data
);

  logic w_s8;
  logic w_s16;

  always_comb begin
    o_raw = i_raw;
    o_raw[{i_idx, 3'b000} +: 8] = i_byte;
  end

  assign w_s8  = i_signed & o_raw[7];
  assign w_s16 = i_signed & o_raw[15];

  always_comb begin
    o_data = o_raw;
    unique case (1'b1)
      i_nbytes == 3'd1:
        o_data = {{24{w_s8}}, o_raw[7:0]};
      i_nbytes == 3'd2:
        o_data = {{16{w_s16}}, o_raw[15:0]};
      default:
        o_data = o_raw;
    endcase
  end

endmodule

// File: rtl/mmu_word_fetcher.sv
// Byte-serial MMU read of 1/2/4 bytes into a word.
// FETCH_TIMEOUT_EN adds a per-byte watchdog abort.
module mmu_word_fetcher
  import mmu_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reqValid,
  input  logic [ADDRESS_WIDTH-1:0] reqAddr,
  input  logic [1:0]               reqSize,
  input  logic                     reqSigned,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              dataOut,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] memAddr,
  output logic                     memRequest,
  input  logic [BUS_WIDTH-1:0]     memData,
  input  logic                     memBusy
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [2:0]               r_nbytes;
  logic                     r_signed;
  logic [1:0]               r_idx;
  logic [31:0]              r_raw;
  logic [31:0]              r_dout;

  logic        w_tmo;
  logic        w_act;
  logic        w_last;
  logic        w_cap;
  logic        w_acc;
  logic [31:0] w_raw;
  logic [31:0] w_asm;

  assign w_act  = (r_state == ST_REQ) |
                  (r_state == ST_WAIT);
  assign w_last = ({1'b0, r_idx} + 3'd1) >= r_nbytes;
  assign w_acc  = (r_state == ST_IDLE) & reqValid;
  assign w_cap  = (r_state == ST_WAIT) & ~memBusy
                  & ~w_tmo;

  fetch_byte_assembler u_asm (
    .i_raw    (r_raw),
    .i_byte   (memData[7:0]),
    .i_idx    (r_idx),
    .i_nbytes (r_nbytes),
    .i_signed (r_signed),
    .o_raw    (w_raw),
    .o_data   (w_asm)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (reqValid) w_next = ST_REQ;
      ST_REQ:  if (memBusy) w_next = ST_WAIT;
      ST_WAIT: begin
        if (!memBusy)
          w_next = w_last ? ST_DONE : ST_REQ;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_tmo) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_nbytes <= 3'd0;
      r_signed <= 1'b0;
      r_idx    <= 2'd0;
      r_raw    <= '0;
      r_dout   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_addr   <= reqAddr;
        r_nbytes <= size_bytes(reqSize);
        r_signed <= reqSigned;
        r_idx    <= 2'd0;
        r_raw    <= '0;
      end
      if (w_cap) begin
        r_raw <= w_raw;
        r_idx <= r_idx + 2'd1;
        if (w_last) r_dout <= w_asm;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo;

  // Restarts for every byte so the limit is per byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (w_next == ST_REQ &&
                 r_state != ST_REQ) begin
      r_tmo <= '0;
    end else if (w_act) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo = w_act &&
    (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
  assign w_tmo = 1'b0;
`endif

  assign busy       = w_act;
  assign done       = (r_state == ST_DONE);
  assign dataOut    = r_dout;
  assign error      = w_tmo;
  assign memRequest = (r_state == ST_REQ) & ~w_tmo;
  assign memAddr    = r_addr +
                      ADDRESS_WIDTH'(r_idx);

endmodule

// File: tb/tb_mmu_word_fetcher.sv
// Randomized self-checking bench for mmu_word_fetcher
// with an in-bench MMU responder and result model.
module tb_mmu_word_fetcher;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [1:0]  reqSize = '0;
  logic        reqSigned = 1'b0;
  logic        memBusy = 1'b0;
  logic [7:0]  memData = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic        memRequest;
  logic [31:0] dataOut;
  logic [31:0] memAddr;

  int checks = 0;
  int errors = 0;
  logic [31:0] held = '0;

  always #5 clk = ~clk;

  mmu_word_fetcher #(
    .ADDRESS_WIDTH  (32),
    .BUS_WIDTH      (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqAddr    (reqAddr),
    .reqSize    (reqSize),
    .reqSigned  (reqSigned),
    .busy       (busy),
    .done       (done),
    .dataOut    (dataOut),
    .error      (error),
    .memAddr    (memAddr),
    .memRequest (memRequest),
    .memData    (memData),
    .memBusy    (memBusy)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h",
               nm, act, exp);
    end
  endtask

  // Little-endian value of n bytes, then extension.
  function automatic logic [31:0] model(
    input logic [31:0] b,
    input int          n,
    input logic        sg
  );
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < n; i++)
      v = v + (32'(b[8*i +: 8]) << (8 * i));
    if (sg && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic run_txn(
    input  logic [31:0] a,
    input  logic [1:0]  sz,
    input  logic        sg,
    input  logic [31:0] bytes,
    input  logic [15:0] stl,
    input  int          abort_at,
    output logic [31:0] got,
    output logic [31:0] last_addr
  );
    int n;
    int bi;
    int cyc;
    int rem;
    int ssum;
    bit inw;
    logic [31:0] exp;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp = model(bytes, n, sg);
    ssum = 0;
    for (int i = 0; i < n; i++)
      ssum += int'(stl[4*i +: 4]);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_hold", dataOut, held);
    reqValid  = 1'b1;
    reqAddr   = a;
    reqSize   = sz;
    reqSigned = sg;
    bi = 0; inw = 0; cyc = 0; rem = 0;
    got = '0; last_addr = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      reqValid  = 1'($urandom);
      reqAddr   = $urandom;
      reqSize   = 2'($urandom);
      reqSigned = 1'($urandom);
      if (cyc > 300) begin
        errors++;
        $display("FAIL timeout_no_done got=%0d want<=300",
                 cyc);
        break;
      end
      chk("error_low", 32'(error), 0);
      if (done) begin
        chk("done_data", dataOut, exp);
        chk("done_busy", 32'(busy), 0);
        chk("nbytes", 32'(bi), 32'(n));
        chk("latency", 32'(cyc + 1),
            32'(2 * n + 2 + ssum));
        got  = dataOut;
        held = exp;
        break;
      end
      chk("busy", 32'(busy), 1);
      chk("memreq", 32'(memRequest), 32'(!inw));
      chk("memaddr", memAddr, a + 32'(bi));
      if (!inw) begin
        last_addr = memAddr;
        if (memRequest) begin
          memBusy = 1'b1;
          rem = int'(stl[4*bi +: 4]);
          inw = 1;
        end
      end else if (abort_at == bi) begin
        reset = 1'b0;
        #1;
        chk("rst_memreq", 32'(memRequest), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_data", dataOut, 0);
        memBusy  = 1'b0;
        reqValid = 1'b0;
        held = '0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end else if (rem > 0) begin
        rem--;
      end else begin
        memBusy = 1'b0;
        memData = bytes[8*bi +: 8];
        bi++;
        inw = 0;
      end
    end
    reqValid = 1'b0;
    memBusy  = 1'b0;
  endtask

  logic [31:0] got;
  logic [31:0] la;
  logic [1:0]  sz;
  logic [15:0] st;

  initial begin
    reqValid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst0_busy", 32'(busy), 0);
    chk("rst0_done", 32'(done), 0);
    chk("rst0_err", 32'(error), 0);
    chk("rst0_req", 32'(memRequest), 0);
    chk("rst0_addr", memAddr, 0);
    chk("rst0_data", dataOut, 0);
    reqValid = 1'b0;
    reset = 1'b1;

    run_txn(32'h100, 2'd2, 1'b0, 32'h4433_2211,
            16'h0, -1, got, la);
    chk("word_lit", got, 32'h4433_2211);
    chk("word_lastaddr", la, 32'h103);

    run_txn(32'h40, 2'd0, 1'b1, 32'h80,
            16'h0, -1, got, la);
    chk("byte_s_lit", got, 32'hFFFF_FF80);
    run_txn(32'h41, 2'd0, 1'b0, 32'h80,
            16'h0, -1, got, la);
    chk("byte_u_lit", got, 32'h0000_0080);

    run_txn(32'hFFFF_FFFF, 2'd1, 1'b0, 32'h1234,
            16'h0, -1, got, la);
    chk("half_wrap_lit", got, 32'h0000_1234);
    chk("half_wrap_addr", la, 32'h0);

    run_txn(32'h200, 2'd2, 1'b0, 32'hDEAD_BEEF,
            16'h0, 1, got, la);
    run_txn(32'h300, 2'd2, 1'b0, 32'hA1B2_C3D4,
            16'h0021, -1, got, la);
    chk("after_rst_lit", got, 32'hA1B2_C3D4);

    for (int t = 0; t < 40; t++) begin
      sz = 2'($urandom);
      st = '0;
      for (int k = 0; k < 4; k++)
        st[4*k +: 4] = 4'($urandom_range(0, 3));
      run_txn($urandom, sz, 1'($urandom),
              $urandom, st, -1, got, la);
    end

`ifdef FETCH_TIMEOUT_EN
    begin
      int c;
      @(negedge clk);
      reqValid = 1'b1;
      reqAddr  = 32'h500;
      reqSize  = 2'd2;
      c = 0;
      while (c < 40) begin
        @(negedge clk);
        c++;
        reqValid = 1'b0;
        if (memRequest) memBusy = 1'b1;
        chk("tmo_nodone", 32'(done), 0);
        if (error) break;
      end
      chk("tmo_cycle", 32'(c), 32'(TMO));
      chk("tmo_req", 32'(memRequest), 0);
      chk("tmo_data", dataOut, held);
      @(negedge clk);
      memBusy = 1'b0;
      chk("tmo_busy", 32'(busy), 0);
      chk("tmo_err", 32'(error), 0);
      chk("tmo_done", 32'(done), 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_word_fetcher.md
MMU_WORD_FETCHER -- requirements
Module: mmu_word_fetcher

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, address width on both sides.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 8, MMU data port width in bits.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in clocks per byte.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 reqValid  input  1  upstream read request, sampled in IDLE only.
REQ-007 reqAddr  input  ADDRESS_WIDTH  byte address of first byte.
REQ-008 reqSize  input  2  0=byte, 1=half, 2=word, 3=treated as word.
REQ-009 reqSigned  input  1  sign-extend byte/half result.
REQ-010 busy  output  1  high from accept cycle until done.
REQ-011 done  output  1  one-cycle pulse, dataOut valid in same cycle.
REQ-012 dataOut  output  32  assembled result, held until next done.
REQ-013 error  output  1  one-cycle pulse on watchdog abort (only with macro).
REQ-014 memAddr  output  ADDRESS_WIDTH  byte address to MMU port.
REQ-015 memRequest  output  1  request to MMU port.
REQ-016 memData  input  BUS_WIDTH  MMU port read data.
REQ-017 memBusy  input  1  MMU port busy; contract: high for at least one posedge per accepted byte.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-019 IDLE: on reqValid=1 the block SHALL latch addr/size/signed, clear byte index, set busy, go to REQ next cycle.
REQ-020 REQ: memRequest=1, memAddr=latched addr + index; on memBusy=1 go to WAIT with memRequest=0 next cycle.
REQ-021 WAIT: on memBusy=0 the block SHALL capture memData into byte lane [index*8 +: 8] (little-endian), increment index.
REQ-022 WAIT exit: if index+1 < size bytes (1/2/4) go to REQ, else go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, busy=0 in same cycle, then IDLE; back-to-back reqValid accepted the cycle after DONE.
REQ-024 Unused upper bits of dataOut SHALL be zero, or copies of the top received bit when reqSigned=1.
REQ-025 reqValid while busy SHALL be ignored; no queueing.
REQ-026 Address increment SHALL wrap modulo 2^ADDRESS_WIDTH; no alignment check.
REQ-027 Minimum latency SHALL be 1 + 2*N + 1 cycles for N bytes when MMU responds in one cycle each.
REQ-028 memAddr SHALL be stable throughout REQ and WAIT of each byte.

Reset
REQ-029 Asserting reset SHALL force IDLE immediately: busy=0, done=0, error=0, memRequest=0, memAddr=0, dataOut=0, index=0, mid-transaction data discarded.
REQ-030 After deassertion the first accept SHALL occur no earlier than the first posedge with reset=1.

Configuration
REQ-031 With FETCH_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and count each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES SHALL pulse error, drop memRequest, leave dataOut unchanged, go to IDLE, no done.
REQ-032 Without FETCH_TIMEOUT_EN, no counter SHALL exist, error SHALL be tied 0, the block waits indefinitely.

Structure
REQ-033 State encoding and reqSize encodings SHALL live in shared package mmu_fetch_pkg.
REQ-034 Lane placement and sign/zero extension SHALL be a sub-module fetch_byte_assembler.

Verification
REQ-035 Word read addr 0x100, MMU bytes 0x11,0x22,0x33,0x44, 1-cycle busy -> memAddr 0x100..0x103, dataOut=0x44332211, done after 10 cycles.
REQ-036 Byte read, memData 0x80, reqSigned=1 -> dataOut=0xFFFFFF80; reqSigned=0 -> 0x00000080.
REQ-037 Half read at 0xFFFFFFFF, bytes 0x34,0x12 -> second memAddr=0x00000000, dataOut=0x00001234.
REQ-038 reset low during WAIT of byte 2 -> memRequest=0, busy=0 same cycle; next word read returns correct fresh data.
REQ-039 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, memBusy stuck high -> error pulse at cycle 8, no done, busy=0 afterward.
REQ-040 reqValid toggled during busy -> ignored; exactly one done per accepted request.
